// File: rtl/window_scan_ctrl.sv
// Serpentine scan sequencer for the 3x3 Sobel window buffer: fetches pixels over a
// request/valid handshake, drives fill/shift strobes and presents each window downstream.
module window_scan_ctrl #(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_valid,
    output logic              start_read,
    output logic              start_shift,
    output logic [1:0]        shift_direc,
    output logic              win_valid,
    input  logic              win_ready,
    output logic [7:0]        win_row,
    output logic [7:0]        win_col,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {IDLE, FILL, EMIT, SHIFT, LOAD, DONE} state_t;

    localparam logic [1:0] MV_FILL  = 2'b00;
    localparam logic [1:0] MV_RIGHT = 2'b01;
    localparam logic [1:0] MV_LEFT  = 2'b10;
    localparam logic [1:0] MV_DOWN  = 2'b11;

    localparam logic [7:0] LAST_ROW = 8'(IMG_H - 3);
    localparam logic [7:0] LAST_COL = 8'(IMG_W - 3);

    state_t      state;
    logic [7:0]  row;
    logic [7:0]  col;
    logic        dir_left;
    logic [3:0]  pix_cnt;

    logic              last_win;
    logic [ADDR_W-1:0] fill_step;
    logic [ADDR_W-1:0] load_step;
    logic [ADDR_W-1:0] load_addr;

    function automatic logic [ADDR_W-1:0] pix_addr(input logic [7:0] r, input logic [7:0] c);
        return ADDR_W'(r) * ADDR_W'(IMG_W) + ADDR_W'(c);
    endfunction

    assign start_read = rd_req & rd_valid;

    always_comb begin
        last_win  = (row == LAST_ROW) && (dir_left ? (col == 8'd0) : (col == LAST_COL));
        // Fill walks three columns, then wraps to the start of the next image row.
        fill_step = ((pix_cnt == 4'd2) || (pix_cnt == 4'd5)) ? ADDR_W'(IMG_W - 2) : ADDR_W'(1);
        load_step = (shift_direc == MV_DOWN) ? ADDR_W'(1) : ADDR_W'(IMG_W);
        // row/col are already updated to the new window when this is used in SHIFT.
        load_addr = '0;
        case (shift_direc)
            MV_RIGHT: load_addr = pix_addr(row, col + 8'd2);
            MV_LEFT:  load_addr = pix_addr(row, col);
            default:  load_addr = pix_addr(row + 8'd2, col);
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= IDLE;
            row         <= '0;
            col         <= '0;
            dir_left    <= 1'b0;
            pix_cnt     <= '0;
            rd_req      <= 1'b0;
            rd_addr     <= '0;
            start_shift <= 1'b0;
            shift_direc <= MV_FILL;
            win_valid   <= 1'b0;
            win_row     <= '0;
            win_col     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= FILL;
                        row         <= '0;
                        col         <= '0;
                        dir_left    <= 1'b0;
                        pix_cnt     <= '0;
                        rd_req      <= 1'b1;
                        rd_addr     <= '0;
                        shift_direc <= MV_FILL;
                        busy        <= 1'b1;
                    end
                end
                FILL: begin
                    if (start_read) begin
                        if (pix_cnt == 4'd8) begin
                            state     <= EMIT;
                            rd_req    <= 1'b0;
                            rd_addr   <= '0;
                            win_valid <= 1'b1;
                            win_row   <= row;
                            win_col   <= col;
                        end else begin
                            pix_cnt <= pix_cnt + 4'd1;
                            rd_addr <= rd_addr + fill_step;
                        end
                    end
                end
                EMIT: begin
                    if (win_ready) begin
                        win_valid <= 1'b0;
                        if (last_win) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state       <= SHIFT;
                            start_shift <= 1'b1;
                            if (!dir_left && (col < LAST_COL)) begin
                                shift_direc <= MV_RIGHT;
                                col         <= col + 8'd1;
                            end else if (dir_left && (col != 8'd0)) begin
                                shift_direc <= MV_LEFT;
                                col         <= col - 8'd1;
                            end else begin
                                shift_direc <= MV_DOWN;
                                row         <= row + 8'd1;
                                dir_left    <= ~dir_left;
                            end
                        end
                    end
                end
                SHIFT: begin
                    state       <= LOAD;
                    start_shift <= 1'b0;
                    pix_cnt     <= '0;
                    rd_req      <= 1'b1;
                    rd_addr     <= load_addr;
                end
                LOAD: begin
                    if (start_read) begin
                        if (pix_cnt == 4'd2) begin
                            state       <= EMIT;
                            rd_req      <= 1'b0;
                            rd_addr     <= '0;
                            shift_direc <= MV_FILL;
                            win_valid   <= 1'b1;
                            win_row     <= row;
                            win_col     <= col;
                        end else begin
                            pix_cnt <= pix_cnt + 4'd1;
                            rd_addr <= rd_addr + load_step;
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    done     <= 1'b0;
                    busy     <= 1'b0;
                    row      <= '0;
                    col      <= '0;
                    dir_left <= 1'b0;
                    win_row  <= '0;
                    win_col  <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Directed bench for window_scan_ctrl on a 5x4 image with a configurable-latency memory model.
module tb_window_scan_ctrl;

    localparam int W  = 5;
    localparam int H  = 4;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          start = 1'b0;
    logic          rd_valid = 1'b0;
    logic          win_ready = 1'b0;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          start_read;
    logic          start_shift;
    logic [1:0]    shift_direc;
    logic          win_valid;
    logic [7:0]    win_row;
    logic [7:0]    win_col;
    logic          busy;
    logic          done;

    window_scan_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
        .clk(clk), .n_rst(n_rst), .start(start),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid),
        .start_read(start_read), .start_shift(start_shift), .shift_direc(shift_direc),
        .win_valid(win_valid), .win_ready(win_ready), .win_row(win_row), .win_col(win_col),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int mem_wait = 0;
    int wait_cnt = 0;

    logic [AW-1:0] addr_q[$];
    logic [1:0]    shift_q[$];
    logic [15:0]   win_q[$];
    int            done_cnt = 0;
    int            stab_err = 0;
    int            overlap_err = 0;
    logic          prev_req = 1'b0;
    logic          prev_acc = 1'b0;
    logic [AW-1:0] prev_addr = '0;

    int          exp_addr[24] = '{0, 1, 2, 5, 6, 7, 10, 11, 12,
                                  3, 8, 13,  4, 9, 14,  17, 18, 19,
                                  6, 11, 16,  5, 10, 15};
    logic [15:0] exp_win[6]   = '{16'h0000, 16'h0001, 16'h0002, 16'h0102, 16'h0101, 16'h0100};
    logic [1:0]  exp_shift[5] = '{2'b01, 2'b01, 2'b11, 2'b10, 2'b10};

    // Memory answers after mem_wait idle cycles of a pending request.
    always @(negedge clk) rd_valid = rd_req && (wait_cnt >= mem_wait);
    always @(posedge clk) wait_cnt <= (rd_req && !start_read) ? wait_cnt + 1 : 0;

    always begin
        @(negedge clk);
        #2;
        if (start_read) addr_q.push_back(rd_addr);
        if (start_shift) shift_q.push_back(shift_direc);
        if (win_valid && win_ready) win_q.push_back({win_row, win_col});
        if (done) done_cnt++;
        if (start_read && start_shift) overlap_err++;
        if (rd_req && prev_req && !prev_acc && (rd_addr !== prev_addr)) stab_err++;
        prev_req  = rd_req;
        prev_acc  = start_read;
        prev_addr = rd_addr;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_logs;
        addr_q.delete();
        shift_q.delete();
        win_q.delete();
        done_cnt = 0;
        stab_err = 0;
        overlap_err = 0;
    endtask

    // Leaves the caller at the sample point of the first cycle after start was taken.
    task automatic pulse_start;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #2;
    endtask

    task automatic run_to_done(output int cyc);
        cyc = -1;
        for (int k = 1; k <= 3000; k++) begin
            @(negedge clk);
            #2;
            if (done) begin
                cyc = k;
                return;
            end
        end
    endtask

    task automatic test_reset;
        n_rst = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        n_checks++;
        if ({rd_req, start_read, start_shift, win_valid, busy, done} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 000000", {rd_req, start_read, start_shift, win_valid, busy, done});
        end
        n_checks++;
        if (rd_addr !== '0) begin
            n_fail++;
            $display("FAIL reset_addr: got %0d expected 0", rd_addr);
        end
        n_checks++;
        if ({win_row, win_col, shift_direc} !== 18'b0) begin
            n_fail++;
            $display("FAIL reset_win: got row %0d col %0d dir %b expected 0 0 00", win_row, win_col, shift_direc);
        end
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    task automatic test_frame_zero_wait;
        int first_wv;
        int done_k;
        int bad;
        mem_wait  = 0;
        win_ready = 1'b1;
        clear_logs();
        pulse_start();
        n_checks++;
        if ({rd_req, busy} !== 2'b11 || rd_addr !== '0) begin
            n_fail++;
            $display("FAIL first_req: got req %b busy %b addr %0d expected 1 1 0", rd_req, busy, rd_addr);
        end
        first_wv = -1;
        done_k   = -1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            #2;
            if (win_valid && first_wv < 0) first_wv = k;
            if (done) begin
                done_k = k;
                break;
            end
        end
        n_checks++;
        if (first_wv !== 9) begin
            n_fail++;
            $display("FAIL first_win_latency: got %0d expected 9", first_wv);
        end
        n_checks++;
        if (done_k !== 35) begin
            n_fail++;
            $display("FAIL done_latency: got %0d expected 35", done_k);
        end
        bad = 0;
        for (int i = 0; i < 24; i++) if (i >= addr_q.size() || addr_q[i] !== AW'(exp_addr[i])) bad++;
        n_checks++;
        if (addr_q.size() !== 24 || bad !== 0) begin
            n_fail++;
            $display("FAIL zw_addr_seq: got %0d reads, %0d wrong, expected 24 reads, 0 wrong", addr_q.size(), bad);
        end
        bad = 0;
        for (int i = 0; i < 6; i++) if (i >= win_q.size() || win_q[i] !== exp_win[i]) bad++;
        n_checks++;
        if (win_q.size() !== 6 || bad !== 0) begin
            n_fail++;
            $display("FAIL zw_windows: got %0d windows, %0d wrong, expected 6, 0 wrong", win_q.size(), bad);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) if (i >= shift_q.size() || shift_q[i] !== exp_shift[i]) bad++;
        n_checks++;
        if (shift_q.size() !== 5 || bad !== 0) begin
            n_fail++;
            $display("FAIL zw_shift_codes: got %0d shifts, %0d wrong, expected 5, 0 wrong", shift_q.size(), bad);
        end
        n_checks++;
        if (overlap_err !== 0) begin
            n_fail++;
            $display("FAIL read_shift_overlap: got %0d expected 0", overlap_err);
        end
        @(negedge clk);
        #2;
        n_checks++;
        if ({busy, done} !== 2'b00 || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL zw_done_pulse: got busy %b done %b pulses %0d expected 0 0 1", busy, done, done_cnt);
        end
    endtask

    task automatic test_wait_states;
        int cyc;
        int bad;
        mem_wait  = 3;
        win_ready = 1'b1;
        clear_logs();
        pulse_start();
        run_to_done(cyc);
        n_checks++;
        if (cyc < 0) begin
            n_fail++;
            $display("FAIL ws_timeout: got no done, expected done");
        end
        bad = 0;
        for (int i = 0; i < 24; i++) if (i >= addr_q.size() || addr_q[i] !== AW'(exp_addr[i])) bad++;
        n_checks++;
        if (addr_q.size() !== 24 || bad !== 0) begin
            n_fail++;
            $display("FAIL ws_addr_seq: got %0d reads, %0d wrong, expected 24 reads, 0 wrong", addr_q.size(), bad);
        end
        n_checks++;
        if (stab_err !== 0) begin
            n_fail++;
            $display("FAIL ws_addr_stable: got %0d changes while waiting, expected 0", stab_err);
        end
        n_checks++;
        if (win_q.size() !== 6) begin
            n_fail++;
            $display("FAIL ws_window_count: got %0d expected 6", win_q.size());
        end
        mem_wait = 0;
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        int found;
        int bad;
        int cyc;
        mem_wait  = 0;
        win_ready = 1'b0;
        clear_logs();
        pulse_start();
        found = 0;
        for (int k = 0; k < 50 && found == 0; k++) begin
            @(negedge clk);
            #2;
            if (win_valid) found = 1;
        end
        @(negedge clk);
        win_ready = 1'b1;
        @(negedge clk);
        win_ready = 1'b0;
        #2;
        for (int k = 0; k < 20 && found == 1; k++) begin
            if (win_valid) found = 2;
            else begin
                @(negedge clk);
                #2;
            end
        end
        n_checks++;
        if (found !== 2 || win_row !== 8'd0 || win_col !== 8'd1) begin
            n_fail++;
            $display("FAIL bp_second_window: got found %0d row %0d col %0d expected 2 0 1", found, win_row, win_col);
        end
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #2;
            if (!(win_valid === 1'b1 && win_row === 8'd0 && win_col === 8'd1 &&
                  rd_req === 1'b0 && start_shift === 1'b0)) bad++;
        end
        n_checks++;
        if (bad !== 0 || addr_q.size() !== 12) begin
            n_fail++;
            $display("FAIL bp_hold: got %0d bad cycles, %0d reads, expected 0, 12", bad, addr_q.size());
        end
        @(negedge clk);
        win_ready = 1'b1;
        run_to_done(cyc);
        bad = 0;
        for (int i = 0; i < 6; i++) if (i >= win_q.size() || win_q[i] !== exp_win[i]) bad++;
        n_checks++;
        if (cyc < 0 || win_q.size() !== 6 || bad !== 0 || addr_q.size() !== 24) begin
            n_fail++;
            $display("FAIL bp_frame: got done %0d windows %0d wrong %0d reads %0d expected >0 6 0 24",
                     cyc, win_q.size(), bad, addr_q.size());
        end
        @(negedge clk);
    endtask

    task automatic test_start_ignored;
        int cyc;
        int bad;
        mem_wait  = 0;
        win_ready = 1'b1;
        clear_logs();
        pulse_start();
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        start = 1'b1;
        #2;
        n_checks++;
        if (win_valid !== 1'b1 || win_row !== 8'd0 || win_col !== 8'd0) begin
            n_fail++;
            $display("FAIL si_in_emit: got valid %b row %0d col %0d expected 1 0 0", win_valid, win_row, win_col);
        end
        @(negedge clk);
        start = 1'b0;
        run_to_done(cyc);
        bad = 0;
        for (int i = 0; i < 24; i++) if (i >= addr_q.size() || addr_q[i] !== AW'(exp_addr[i])) bad++;
        n_checks++;
        if (cyc < 0 || addr_q.size() !== 24 || bad !== 0 || win_q.size() !== 6) begin
            n_fail++;
            $display("FAIL si_frame: got done %0d reads %0d wrong %0d windows %0d expected >0 24 0 6",
                     cyc, addr_q.size(), bad, win_q.size());
        end
        repeat (3) @(negedge clk);
        #2;
        n_checks++;
        if ({rd_req, busy} !== 2'b00 || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL si_no_restart: got req %b busy %b pulses %0d expected 0 0 1", rd_req, busy, done_cnt);
        end
    endtask

    task automatic test_reset_mid_load;
        int found;
        int cyc;
        int bad;
        mem_wait  = 3;
        win_ready = 1'b1;
        clear_logs();
        pulse_start();
        found = 0;
        for (int k = 0; k < 300 && found == 0; k++) begin
            @(negedge clk);
            #2;
            if (rd_req && shift_q.size() > 0) found = 1;
        end
        n_checks++;
        if (found !== 1) begin
            n_fail++;
            $display("FAIL rml_reach_load: got %0d expected 1", found);
        end
        #1;
        n_rst = 1'b0;
        #1;
        n_checks++;
        if ({rd_req, start_read, start_shift, win_valid, busy, done} !== 6'b0 ||
            rd_addr !== '0 || shift_direc !== 2'b00) begin
            n_fail++;
            $display("FAIL rml_outputs: got ctrl %b addr %0d dir %b expected 000000 0 00",
                     {rd_req, start_read, start_shift, win_valid, busy, done}, rd_addr, shift_direc);
        end
        n_checks++;
        if ({win_row, win_col} !== 16'h0000) begin
            n_fail++;
            $display("FAIL rml_win_pos: got row %0d col %0d expected 0 0", win_row, win_col);
        end
        @(negedge clk);
        n_rst    = 1'b1;
        mem_wait = 0;
        clear_logs();
        pulse_start();
        n_checks++;
        if (rd_req !== 1'b1 || rd_addr !== '0) begin
            n_fail++;
            $display("FAIL rml_restart: got req %b addr %0d expected 1 0", rd_req, rd_addr);
        end
        run_to_done(cyc);
        bad = 0;
        for (int i = 0; i < 24; i++) if (i >= addr_q.size() || addr_q[i] !== AW'(exp_addr[i])) bad++;
        for (int i = 0; i < 6; i++) if (i >= win_q.size() || win_q[i] !== exp_win[i]) bad++;
        n_checks++;
        if (cyc < 0 || bad !== 0) begin
            n_fail++;
            $display("FAIL rml_frame: got done %0d wrong items %0d expected >0 0", cyc, bad);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_frame_zero_wait();
        test_wait_states();
        test_backpressure();
        test_start_ignored();
        test_reset_mid_load();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
